xgmm_upload_engine: RTL
=======================

Name: xgmm_upload_engine

Overview:
- Consumer end of the graphics register-interface upload path.
- Drains the pattern FIFO and the attribute FIFO, which the CPU fills through the register interface, and writes each word into pattern RAM or attribute RAM.
- Takes the write address from the interface's auto-incrementing par/aar pointers.
- Drives the pop pulses that advance those pointers, and yields to display fetches through vram_busy.

Parameters:
- SETTLE_CYCLES, 2, idle cycles after each pop before the next arbitration. Minimum 2, so that the pointer and burst updates (pop falling edge plus one register stage) are visible.

Ports:
- clk_sys  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- p_empty  in  1  pattern FIFO empty
- a_empty  in  1  attribute FIFO empty
- p_data  in  16  pattern FIFO head word (first-word-fall-through, valid while !p_empty)
- a_data  in  16  attribute FIFO head word (first-word-fall-through)
- par  in  12  pattern address pointer (4-word granule)
- aar  in  15  attribute address pointer (advances by 4 per word)
- vram_busy  in  1  display fetch owns the RAM ports this cycle
- p_pop  out  1  pattern FIFO pop, single-cycle pulse
- a_pop  out  1  attribute FIFO pop, single-cycle pulse
- pat_addr  out  14  pattern RAM word address
- pat_wdata  out  16  pattern RAM write data
- pat_wren  out  1  pattern RAM write strobe
- attr_addr  out  13  attribute RAM word address
- attr_wdata  out  16  attribute RAM write data
- attr_wren  out  1  attribute RAM write strobe
- upl_active  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset (async, rst_n low):
  - FSM to IDLE; bcnt=0, last_src=attribute, settle counter=0, prev_p_pop=0.
  - All address and data outputs are 0; all strobes and pops are 0.
- FSM states: IDLE, P_WR, A_WR, SETTLE.
- IDLE:
  - If only !p_empty, go to P_WR. If only !a_empty, go to A_WR.
  - If both are non-empty, serve the source opposite last_src (round-robin). Update last_src on entry.
  - On entry to P_WR, register pat_addr={par,bcnt} and pat_wdata=p_data.
  - On entry to A_WR, register attr_addr=aar[14:2] (aar[1:0] ignored) and attr_wdata=a_data.
- P_WR / A_WR:
  - pat_wren=p_pop=(state==P_WR)&~vram_busy. attr_wren=a_pop=(state==A_WR)&~vram_busy.
  - These strobes are combinational, so the write and the pop share one cycle.
  - While vram_busy=1, hold the state and the registered addr/data; no strobe, no pop.
  - In the cycle the strobe fires, go to SETTLE with counter=SETTLE_CYCLES-1.
- SETTLE:
  - Decrement the counter; go to IDLE when it reaches 0.
  - Minimum transfer period is 2+SETTLE_CYCLES clocks (4 at default).
- Burst counter bcnt (2 bit) mirrors the interface's own counter exactly. Each edge:
  - if p_empty, bcnt=0;
  - else if prev_p_pop & ~p_pop, bcnt+=1 (wraps 3->0);
  - the empty clear has priority.
- Pattern addressing consequences:
  - 4 consecutive words fill one par granule.
  - If the FIFO drains mid-burst, the next word restarts at offset 0 of the same par.
- Strobes are single-cycle and never occur in the same cycle as each other; pops are never issued while the corresponding FIFO is empty.
- Pointer values are sampled only in IDLE. A CPU rewrite of par/aar during P_WR/A_WR/SETTLE affects the next transfer, not the pending one.
- Reset mid-transfer drops the pending word without a pop; the word remains in the FIFO.

Test Plan:
- par=0x012, preload 1 pattern word 0xBEEF -> one pat_wren with pat_addr=0x048 and data 0xBEEF. Exactly one p_pop, coincident with the strobe. upl_active low 4 cycles after the write cycle.
- par=0x012, preload 5 pattern words -> pat_addr sequence 0x048,0x049,0x04A,0x04B,0x04C. Strobes spaced 4 cycles apart. Data in FIFO order.
- Both FIFOs preloaded with 2 words each, aar=0x0010 -> service order pattern, attribute, pattern, attribute. attr_addr=0x004 then 0x005.
- vram_busy held high 5 cycles after entry to P_WR -> no strobe/pop during the stall. Strobe fires in the first cycle busy is low, with the address unchanged.
- 2 pattern words written with the FIFO then empty, then 1 more pushed -> third write at offset 0 of the same par (0x048), not 0x04A.
- rst_n low while in P_WR with vram_busy=1 -> all outputs 0 immediately, no pop. After release the same word is written once.

Source files
------------

// File: rtl/xgmm_upload_engine.sv
// Upload engine: drains the pattern/attribute FIFOs into pattern/attribute RAM,
// addressing from the interface pointers and yielding to display fetches.
module xgmm_upload_engine #(
   parameter int SETTLE_CYCLES = 2
) (
   input  logic        clk_sys,
   input  logic        rst_n,
   input  logic        p_empty,
   input  logic        a_empty,
   input  logic [15:0] p_data,
   input  logic [15:0] a_data,
   input  logic [11:0] par,
   input  logic [14:0] aar,
   input  logic        vram_busy,
   output logic        p_pop,
   output logic        a_pop,
   output logic [13:0] pat_addr,
   output logic [15:0] pat_wdata,
   output logic        pat_wren,
   output logic [12:0] attr_addr,
   output logic [15:0] attr_wdata,
   output logic        attr_wren,
   output logic        upl_active
);

   localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   typedef enum logic [1:0] {IDLE, P_WR, A_WR, SETTLE} state_t;

   state_t          state_r;
   logic [1:0]      bcnt_r;
   logic            last_src_r;   // 1 = attribute was served last
   logic [CW-1:0]   settle_cnt_r;
   logic            prev_p_pop_r;
   logic            take_p_s;
   logic            take_a_s;
   logic            unused_s;

   // Round-robin only matters when both FIFOs hold data
   assign take_p_s = ~p_empty & (a_empty | last_src_r);
   assign take_a_s = ~a_empty & (p_empty | ~last_src_r);

   // Write and pop share one cycle so the pointer advances with the write
   assign p_pop      = (state_r == P_WR) & ~vram_busy;
   assign a_pop      = (state_r == A_WR) & ~vram_busy;
   assign pat_wren   = p_pop;
   assign attr_wren  = a_pop;
   assign upl_active = (state_r != IDLE);
   assign unused_s   = ^aar[1:0];

   // Transfer FSM, registered address/data and mirrored burst counter
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= IDLE;
         bcnt_r       <= 2'd0;
         last_src_r   <= 1'b1;
         settle_cnt_r <= '0;
         prev_p_pop_r <= 1'b0;
         pat_addr     <= 14'd0;
         pat_wdata    <= 16'd0;
         attr_addr    <= 13'd0;
         attr_wdata   <= 16'd0;
      end else begin
         prev_p_pop_r <= p_pop;
         // Must track the interface counter: empty clears it, pop falling edge bumps it
         if (p_empty) begin
            bcnt_r <= 2'd0;
         end else if (prev_p_pop_r & ~p_pop) begin
            bcnt_r <= bcnt_r + 2'd1;
         end else begin
            bcnt_r <= bcnt_r;
         end
         case (state_r)
            IDLE: begin
               if (take_p_s) begin
                  state_r    <= P_WR;
                  last_src_r <= 1'b0;
                  pat_addr   <= {par, bcnt_r};
                  pat_wdata  <= p_data;
               end else if (take_a_s) begin
                  state_r    <= A_WR;
                  last_src_r <= 1'b1;
                  attr_addr  <= aar[14:2];
                  attr_wdata <= a_data;
               end else begin
                  state_r <= IDLE;
               end
            end
            P_WR, A_WR: begin
               if (!vram_busy) begin
                  state_r      <= SETTLE;
                  settle_cnt_r <= CW'(SETTLE_CYCLES - 1);
               end else begin
                  state_r <= state_r;
               end
            end
            SETTLE: begin
               if (settle_cnt_r == '0) begin
                  state_r <= IDLE;
               end else begin
                  settle_cnt_r <= settle_cnt_r - CW'(1);
               end
            end
            default: state_r <= IDLE;
         endcase
      end
   end

endmodule
